// File: rtl/dice_game_pkg.sv
// Shared types for the dice turn game: die colours, turn FSM states and
// the colour-to-step mapping used by the sequencer.
package dice_game_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE = 2'b00,
    RED        = 2'b01,
    GREEN      = 2'b10,
    BLUE       = 2'b11
  } color_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_DICE = 3'd2,
    MOVE      = 3'd3,
    CHECK     = 3'd4,
    DONE      = 3'd5
  } turn_state_e;

  function automatic logic [2:0] color_to_steps(input color_e color,
                                                input logic [2:0] r,
                                                input logic [2:0] g,
                                                input logic [2:0] b);
    logic [2:0] steps;
    case (color)
      RED:     steps = r;
      GREEN:   steps = g;
      BLUE:    steps = b;
      default: steps = 3'd0;
    endcase
    return steps;
  endfunction

endpackage

// File: rtl/dice_turn_sequencer_level_hold_filter.sv
// Flags when a level input has stayed high for WHITE_HOLD_CYCLES consecutive
// cycles; the count restarts whenever the level drops or clear is asserted.
module level_hold_filter #(
  parameter int unsigned WHITE_HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  input  logic clear,
  output logic held
);

  localparam int unsigned CNT_W = $clog2(WHITE_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WHITE_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WHITE_HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !level_in)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires on the last qualifying cycle so the consumer moves on the next edge.
  assign held = !clear && level_in && (cnt_q == CNT_LAST);

endmodule

// File: rtl/dice_turn_sequencer.sv
// Turn sequencer for the dice board game: takes one die colour per armed turn,
// advances the active player on a saturating track and rotates turns.
module dice_turn_sequencer
  import dice_game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS       = 2,
  parameter int unsigned TRACK_LEN         = 30,
  parameter int unsigned RED_STEPS         = 1,
  parameter int unsigned GREEN_STEPS       = 2,
  parameter int unsigned BLUE_STEPS        = 3,
  parameter int unsigned WHITE_HOLD_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  stable_color,
  input  logic        result_ready,
  input  logic        current_state_white,
  output logic [1:0]  active_player,
  output logic [31:0] player_pos,
  output logic        move_valid,
  output logic [2:0]  move_steps,
  output logic [1:0]  last_color,
  output logic        turn_armed,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [2:0]  dbg_state
);

  localparam logic [7:0] GOAL        = 8'(TRACK_LEN - 1);
  localparam logic [1:0] LAST_PLAYER = 2'(NUM_PLAYERS - 1);

  turn_state_e       state_q, state_d;
  logic [1:0]        ap_q, ap_d;
  logic [3:0][7:0]   pos_q, pos_d;
  logic              move_valid_q, move_valid_d;
  logic [2:0]        move_steps_q, move_steps_d;
  logic [1:0]        last_color_q, last_color_d;
  logic              turn_armed_q, turn_armed_d;
  logic              game_over_q, game_over_d;
  logic [1:0]        winner_q, winner_d;
  logic              white_held;
  logic [2:0]        steps;

  function automatic logic [7:0] sat_add(input logic [7:0] pos, input logic [2:0] inc);
    logic [8:0] sum;
    sum = {1'b0, pos} + {6'b0, inc};
    if (sum >= {1'b0, GOAL})
      return GOAL;
    return sum[7:0];
  endfunction

  level_hold_filter #(
    .WHITE_HOLD_CYCLES(WHITE_HOLD_CYCLES)
  ) u_white_hold (
    .clk     (clk),
    .reset   (reset),
    .level_in(current_state_white),
    .clear   ((state_q != ARM) || start),
    .held    (white_held)
  );

  assign steps = color_to_steps(color_e'(stable_color), 3'(RED_STEPS),
                                3'(GREEN_STEPS), 3'(BLUE_STEPS));

  always_comb begin
    state_d      = state_q;
    ap_d         = ap_q;
    pos_d        = pos_q;
    move_valid_d = 1'b0;
    move_steps_d = move_steps_q;
    last_color_d = last_color_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    if (start) begin
      state_d     = ARM;
      ap_d        = 2'd0;
      pos_d       = '0;
      game_over_d = 1'b0;
      winner_d    = 2'd0;
    end else begin
      case (state_q)
        ARM: if (white_held) state_d = WAIT_DICE;
        WAIT_DICE: begin
          if (result_ready && (stable_color != 2'b00)) begin
            state_d        = MOVE;
            pos_d[ap_q]    = sat_add(pos_q[ap_q], steps);
            move_valid_d   = 1'b1;
            move_steps_d   = steps;
            last_color_d   = stable_color;
          end
        end
        // Goal test is resolved here so game_over / turn advance are visible in CHECK.
        MOVE: begin
          state_d = CHECK;
          if (pos_q[ap_q] == GOAL) begin
            game_over_d = 1'b1;
            winner_d    = ap_q;
          end else begin
            ap_d = (ap_q == LAST_PLAYER) ? 2'd0 : ap_q + 2'd1;
          end
        end
        CHECK:   state_d = game_over_q ? DONE : ARM;
        IDLE, DONE: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
    turn_armed_d = (state_d == WAIT_DICE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ap_q         <= 2'd0;
      pos_q        <= '0;
      move_valid_q <= 1'b0;
      move_steps_q <= 3'd0;
      last_color_q <= 2'd0;
      turn_armed_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      ap_q         <= ap_d;
      pos_q        <= pos_d;
      move_valid_q <= move_valid_d;
      move_steps_q <= move_steps_d;
      last_color_q <= last_color_d;
      turn_armed_q <= turn_armed_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
    end
  end

  assign active_player = ap_q;
  assign player_pos    = pos_q;
  assign move_valid    = move_valid_q;
  assign move_steps    = move_steps_q;
  assign last_color    = last_color_q;
  assign turn_armed    = turn_armed_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dice_turn_sequencer.sv
// Directed bench for dice_turn_sequencer: three players, 30-square track,
// 1024-cycle white hold, expected values from a small turn model.
module tb_dice_turn_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  stable_color = 2'b00;
  logic        result_ready = 1'b0;
  logic        current_state_white = 1'b0;
  logic [1:0]  active_player;
  logic [31:0] player_pos;
  logic        move_valid;
  logic [2:0]  move_steps;
  logic [1:0]  last_color;
  logic        turn_armed;
  logic        game_over;
  logic [1:0]  winner;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int mpos[3];
  int map;

  localparam int GOAL = 29;

  dice_turn_sequencer #(
    .NUM_PLAYERS(3), .TRACK_LEN(30), .RED_STEPS(1), .GREEN_STEPS(2),
    .BLUE_STEPS(3), .WHITE_HOLD_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stable_color(stable_color),
    .result_ready(result_ready), .current_state_white(current_state_white),
    .active_player(active_player), .player_pos(player_pos), .move_valid(move_valid),
    .move_steps(move_steps), .last_color(last_color), .turn_armed(turn_armed),
    .game_over(game_over), .winner(winner), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ap"}, {30'd0, active_player}, 0);
    chk({tag, "_pos"}, player_pos, 0);
    chk({tag, "_mv"}, {31'd0, move_valid}, 0);
    chk({tag, "_steps"}, {29'd0, move_steps}, 0);
    chk({tag, "_color"}, {30'd0, last_color}, 0);
    chk({tag, "_armed"}, {31'd0, turn_armed}, 0);
    chk({tag, "_go"}, {31'd0, game_over}, 0);
    chk({tag, "_winner"}, {30'd0, winner}, 0);
    chk({tag, "_state"}, {29'd0, dbg_state}, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mpos[0] = 0; mpos[1] = 0; mpos[2] = 0;
    map = 0;
  endtask

  task automatic wait_armed();
    for (int i = 0; i < 3000; i++) begin
      if (turn_armed) break;
      @(negedge clk);
    end
    chk("armed_wait", {31'd0, turn_armed}, 1);
  endtask

  task automatic take_turn(input logic [1:0] col, input int st);
    int exp;
    wait_armed();
    result_ready = 1'b1;
    stable_color = col;
    @(negedge clk);
    result_ready = 1'b0;
    stable_color = 2'b00;
    exp = mpos[map] + st;
    if (exp > GOAL) exp = GOAL;
    mpos[map] = exp;
    chk("mv_valid", {31'd0, move_valid}, 1);
    chk("mv_pos", {24'd0, player_pos[8*map +: 8]}, exp);
    chk("mv_steps", {29'd0, move_steps}, st);
    chk("mv_color", {30'd0, last_color}, {30'd0, col});
    chk("ap_hold", {30'd0, active_player}, map);
    @(negedge clk);
    chk("mv_pulse", {31'd0, move_valid}, 0);
    chk("state_check", {29'd0, dbg_state}, 4);
    if (exp == GOAL) begin
      chk("game_over", {31'd0, game_over}, 1);
      chk("winner", {30'd0, winner}, map);
    end else begin
      map = (map + 1) % 3;
      chk("ap_next", {30'd0, active_player}, map);
      chk("not_over", {31'd0, game_over}, 0);
    end
  endtask

  initial begin
    mpos[0] = 0; mpos[1] = 0; mpos[2] = 0;
    map = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold", {29'd0, dbg_state}, 0);

    // Test 1: arm after exactly 1024 white cycles, RED move
    do_start();
    chk("start_arm", {29'd0, dbg_state}, 1);
    current_state_white = 1'b1;
    repeat (1023) @(negedge clk);
    chk("t1_not_armed", {31'd0, turn_armed}, 0);
    @(negedge clk);
    chk("t1_armed", {31'd0, turn_armed}, 1);
    chk("t1_state", {29'd0, dbg_state}, 2);
    take_turn(2'b01, 1);
    chk("t1_p0", player_pos, 32'h0000_0001);

    // Test 2: white interrupted after 1000 cycles restarts the hold window
    current_state_white = 1'b0;
    @(negedge clk);
    chk("t2_arm", {29'd0, dbg_state}, 1);
    current_state_white = 1'b1;
    repeat (500) @(negedge clk);
    result_ready = 1'b1;
    stable_color = 2'b01;
    @(negedge clk);
    result_ready = 1'b0;
    chk("t2_no_move", {31'd0, move_valid}, 0);
    chk("t2_pos_kept", player_pos, 32'h0000_0001);
    repeat (499) @(negedge clk);
    current_state_white = 1'b0;
    @(negedge clk);
    current_state_white = 1'b1;
    repeat (1023) @(negedge clk);
    chk("t2_not_armed", {31'd0, turn_armed}, 0);
    @(negedge clk);
    chk("t2_armed", {31'd0, turn_armed}, 1);
    take_turn(2'b10, 2);
    chk("t2_pos", player_pos, 32'h0000_0201);

    // Test 5: NONE is ignored; start beats a simultaneous result_ready
    wait_armed();
    result_ready = 1'b1;
    stable_color = 2'b00;
    @(negedge clk);
    result_ready = 1'b0;
    chk("t5_none_mv", {31'd0, move_valid}, 0);
    chk("t5_none_armed", {31'd0, turn_armed}, 1);
    chk("t5_ap2", {30'd0, active_player}, 2);
    result_ready = 1'b1;
    stable_color = 2'b11;
    do_start();
    result_ready = 1'b0;
    chk("t5_state", {29'd0, dbg_state}, 1);
    chk("t5_pos", player_pos, 0);
    chk("t5_mv", {31'd0, move_valid}, 0);
    chk("t5_ap", {30'd0, active_player}, 0);
    chk("t5_armed", {31'd0, turn_armed}, 0);

    // Test 4: three GREEN turns rotate 0->1->2->0
    take_turn(2'b10, 2);
    take_turn(2'b10, 2);
    take_turn(2'b10, 2);
    chk("t4_pos", player_pos, 32'h0002_0202);
    chk("t4_ap", {30'd0, active_player}, 0);

    // Test 3: drive p0 to 28, then BLUE saturates at the goal
    do_start();
    for (int r = 0; r < 9; r++) begin
      take_turn(2'b11, 3);
      take_turn(2'b01, 1);
      take_turn(2'b01, 1);
    end
    take_turn(2'b01, 1);
    take_turn(2'b01, 1);
    take_turn(2'b01, 1);
    chk("t3_p0_28", {24'd0, player_pos[7:0]}, 28);
    take_turn(2'b11, 3);
    chk("t3_p0_sat", {24'd0, player_pos[7:0]}, 29);
    @(negedge clk);
    chk("t3_done", {29'd0, dbg_state}, 5);
    repeat (5) @(negedge clk);
    result_ready = 1'b1;
    stable_color = 2'b11;
    @(negedge clk);
    result_ready = 1'b0;
    chk("t3_ignored_mv", {31'd0, move_valid}, 0);
    chk("t3_ignored_pos", player_pos, 32'h000a_0a1d);
    chk("t3_still_done", {29'd0, dbg_state}, 5);
    chk("t3_still_over", {31'd0, game_over}, 1);

    // Test 6: reset during MOVE clears everything asynchronously
    do_start();
    chk("t6_cleared", {31'd0, game_over}, 0);
    take_turn(2'b01, 1);
    wait_armed();
    result_ready = 1'b1;
    stable_color = 2'b11;
    @(negedge clk);
    result_ready = 1'b0;
    chk("t6_in_move", {29'd0, dbg_state}, 3);
    chk("t6_mv_seen", {31'd0, move_valid}, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("t6_async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_no_pulse", {31'd0, move_valid}, 0);
    chk("t6_idle", {29'd0, dbg_state}, 0);
    chk("t6_pos", player_pos, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
